// File: rtl/clock_ctrl.sv
// Mode/position sequencer and counter-advance pulse generator for the
// clock, alarm and stopwatch counter banks. Single clock domain, sync reset.
module clock_ctrl #(
  parameter bit SETUP_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_tick_1hz,
  input  logic       i_tick_100hz,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  input  logic       i_sw_hit_ssec,
  input  logic       i_sw_hit_sec,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_sw_ssec_clk,
  output logic       o_sw_sec_clk,
  output logic       o_sw_min_clk,
  output logic       o_alarm_en,
  output logic       o_stopwatch_en
);

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SETUP     = 2'd1,
    MODE_ALARM     = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  mode_t      mode_r, mode_nxt_s;
  pos_t       position_r, pos_nxt_s;
  logic [3:0] btn_s, btn_hist_r, btn_rise_s;
  logic [3:0] hit_s, hit_hist_r, hit_rise_s;
  logic [2:0] man_time_s, man_alarm_s, pos_onehot_s;
  logic       alarm_en_nxt_s, sw_en_nxt_s;
  logic       time_run_s, sw_run_s;

  assign btn_s      = {i_sw3, i_sw2, i_sw1, i_sw0};
  assign hit_s      = {i_sw_hit_sec, i_sw_hit_ssec, i_max_hit_min, i_max_hit_sec};
  assign btn_rise_s = btn_s & ~btn_hist_r;
  assign hit_rise_s = hit_s & ~hit_hist_r;
  assign time_run_s = (SETUP_HOLD == 1'b0) || (mode_r != MODE_SETUP);
  assign sw_run_s   = ~o_stopwatch_en;
  assign o_mode     = mode_r;
  assign o_position = position_r;

  // Decode button events with sw0 > sw1 > sw2 > sw3 priority against the current mode.
  always_comb begin
    mode_nxt_s     = mode_r;
    pos_nxt_s      = position_r;
    man_time_s     = 3'b000;
    man_alarm_s    = 3'b000;
    alarm_en_nxt_s = o_alarm_en;
    sw_en_nxt_s    = o_stopwatch_en;
    case (position_r)
      POS_SEC:  pos_onehot_s = 3'b001;
      POS_MIN:  pos_onehot_s = 3'b010;
      POS_HOUR: pos_onehot_s = 3'b100;
      default:  pos_onehot_s = 3'b000;
    endcase
    if (btn_rise_s[0]) begin
      case (mode_r)
        MODE_CLOCK:  mode_nxt_s = MODE_SETUP;
        MODE_SETUP:  mode_nxt_s = MODE_ALARM;
        MODE_ALARM:  mode_nxt_s = MODE_STOPWATCH;
        default:     mode_nxt_s = MODE_CLOCK;
      endcase
      pos_nxt_s = POS_SEC;
    end else if (btn_rise_s[1]) begin
      if ((mode_r == MODE_SETUP) || (mode_r == MODE_ALARM)) begin
        case (position_r)
          POS_SEC: pos_nxt_s = POS_MIN;
          POS_MIN: pos_nxt_s = POS_HOUR;
          default: pos_nxt_s = POS_SEC;
        endcase
      end else begin
        pos_nxt_s = position_r;
      end
    end else if (btn_rise_s[2]) begin
      if (mode_r == MODE_SETUP) begin
        man_time_s = pos_onehot_s;
      end else if (mode_r == MODE_ALARM) begin
        man_alarm_s = pos_onehot_s;
      end else begin
        man_time_s = 3'b000;
      end
    end else if (btn_rise_s[3]) begin
      if (mode_r == MODE_ALARM) begin
        alarm_en_nxt_s = ~o_alarm_en;
      end else if (mode_r == MODE_STOPWATCH) begin
        sw_en_nxt_s = ~o_stopwatch_en;
      end else begin
        alarm_en_nxt_s = o_alarm_en;
      end
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Register state, edge history and every advance pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r           <= MODE_CLOCK;
      position_r       <= POS_SEC;
      btn_hist_r       <= 4'b0000;
      hit_hist_r       <= 4'b0000;
      o_alarm_en       <= 1'b0;
      o_stopwatch_en   <= 1'b1;
      o_sec_clk        <= 1'b0;
      o_min_clk        <= 1'b0;
      o_hour_clk       <= 1'b0;
      o_alarm_sec_clk  <= 1'b0;
      o_alarm_min_clk  <= 1'b0;
      o_alarm_hour_clk <= 1'b0;
      o_sw_ssec_clk    <= 1'b0;
      o_sw_sec_clk     <= 1'b0;
      o_sw_min_clk     <= 1'b0;
    end else begin
      mode_r           <= mode_nxt_s;
      position_r       <= pos_nxt_s;
      // History tracks inputs even while pulses are gated, so no stale carry fires later.
      btn_hist_r       <= btn_s;
      hit_hist_r       <= hit_s;
      o_alarm_en       <= alarm_en_nxt_s;
      o_stopwatch_en   <= sw_en_nxt_s;
      o_sec_clk        <= (i_tick_1hz & time_run_s) | man_time_s[0];
      o_min_clk        <= (hit_rise_s[0] & time_run_s) | man_time_s[1];
      o_hour_clk       <= (hit_rise_s[1] & time_run_s) | man_time_s[2];
      o_alarm_sec_clk  <= man_alarm_s[0];
      o_alarm_min_clk  <= man_alarm_s[1];
      o_alarm_hour_clk <= man_alarm_s[2];
      o_sw_ssec_clk    <= i_tick_100hz & sw_run_s;
      o_sw_sec_clk     <= hit_rise_s[2] & sw_run_s;
      o_sw_min_clk     <= hit_rise_s[3] & sw_run_s;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: directed walk through the modes, then
// random button/tick/hit traffic checked every cycle against a behavioural model.
module tb_clock_ctrl;
  localparam bit SETUP_HOLD = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_sw0, i_sw1, i_sw2, i_sw3, i_tick_1hz, i_tick_100hz;
  logic       i_max_hit_sec, i_max_hit_min, i_sw_hit_ssec, i_sw_hit_sec;
  logic [1:0] o_mode, o_position;
  logic       o_sec_clk, o_min_clk, o_hour_clk;
  logic       o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk;
  logic       o_sw_ssec_clk, o_sw_sec_clk, o_sw_min_clk;
  logic       o_alarm_en, o_stopwatch_en;

  clock_ctrl #(.SETUP_HOLD(SETUP_HOLD)) dut (
    .clk(clk), .rst(rst),
    .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2), .i_sw3(i_sw3),
    .i_tick_1hz(i_tick_1hz), .i_tick_100hz(i_tick_100hz),
    .i_max_hit_sec(i_max_hit_sec), .i_max_hit_min(i_max_hit_min),
    .i_sw_hit_ssec(i_sw_hit_ssec), .i_sw_hit_sec(i_sw_hit_sec),
    .o_mode(o_mode), .o_position(o_position),
    .o_sec_clk(o_sec_clk), .o_min_clk(o_min_clk), .o_hour_clk(o_hour_clk),
    .o_alarm_sec_clk(o_alarm_sec_clk), .o_alarm_min_clk(o_alarm_min_clk),
    .o_alarm_hour_clk(o_alarm_hour_clk),
    .o_sw_ssec_clk(o_sw_ssec_clk), .o_sw_sec_clk(o_sw_sec_clk), .o_sw_min_clk(o_sw_min_clk),
    .o_alarm_en(o_alarm_en), .o_stopwatch_en(o_stopwatch_en)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] pos;
    logic [2:0] tclk;   // hour, min, sec
    logic [2:0] aclk;   // alarm hour, min, sec
    logic [2:0] swclk;  // stopwatch min, sec, ssec
    logic       alarm_en;
    logic       sw_en;
  } exp_t;

  typedef struct {
    exp_t v;
    int   due;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  // Stimulus levels applied by step(); buttons {sw3..sw0}, hits {sw_sec, sw_ssec, min, sec}.
  bit       st_rst = 1'b1;
  bit [3:0] st_btn = 4'b0000;
  bit [3:0] st_hit = 4'b0000;
  bit       st_t1 = 1'b0;
  bit       st_t100 = 1'b0;

  // Reference model state.
  int       m_mode = 0;
  int       m_pos = 0;
  bit       m_alarm = 1'b0;
  bit       m_stopped = 1'b1;
  bit [7:0] m_prev = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    exp_t     e;
    bit [7:0] cur, rise;
    @(posedge clk);
    #1;
    rst = st_rst;
    {i_sw3, i_sw2, i_sw1, i_sw0} = st_btn;
    {i_sw_hit_sec, i_sw_hit_ssec, i_max_hit_min, i_max_hit_sec} = st_hit;
    i_tick_1hz = st_t1;
    i_tick_100hz = st_t100;
    cur = {st_hit, st_btn};
    e = '0;
    if (st_rst) begin
      m_mode = 0; m_pos = 0; m_alarm = 1'b0; m_stopped = 1'b1; m_prev = 8'h00;
    end else begin
      rise = cur & ~m_prev;
      m_prev = cur;
      if (!(SETUP_HOLD && m_mode == 1)) begin
        e.tclk[0] = st_t1;
        e.tclk[1] = rise[4];
        e.tclk[2] = rise[5];
      end
      if (!m_stopped) begin
        e.swclk[0] = st_t100;
        e.swclk[1] = rise[6];
        e.swclk[2] = rise[7];
      end
      if (rise[0]) begin
        m_mode = (m_mode + 1) % 4;
        m_pos = 0;
      end else if (rise[1]) begin
        if (m_mode == 1 || m_mode == 2) m_pos = (m_pos + 1) % 3;
      end else if (rise[2]) begin
        if (m_mode == 1) e.tclk[m_pos] = 1'b1;
        else if (m_mode == 2) e.aclk[m_pos] = 1'b1;
      end else if (rise[3]) begin
        if (m_mode == 2) m_alarm = !m_alarm;
        else if (m_mode == 3) m_stopped = !m_stopped;
      end
    end
    e.mode = 2'(m_mode);
    e.pos = 2'(m_pos);
    e.alarm_en = m_alarm;
    e.sw_en = m_stopped;
    sb.push_back('{e, cyc + 1});
  endtask

  task automatic press(input int b);
    st_btn[b] = 1'b1;
    step(); step(); step();
    st_btn[b] = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_tick(input bit slow);
    if (slow) st_t1 = 1'b1; else st_t100 = 1'b1;
    step();
    st_t1 = 1'b0;
    st_t100 = 1'b0;
  endtask

  // Monitor: compare the DUT outputs against the scoreboard entry due this cycle.
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        act = {o_mode, o_position, o_hour_clk, o_min_clk, o_sec_clk,
               o_alarm_hour_clk, o_alarm_min_clk, o_alarm_sec_clk,
               o_sw_min_clk, o_sw_sec_clk, o_sw_ssec_clk, o_alarm_en, o_stopwatch_en};
        total++;
        if (act !== it.v) begin
          bad++;
          $display("FAIL outputs cyc=%0d actual=%b required=%b (mode %0d/%0d pos %0d/%0d)",
                   cyc, act, it.v, act.mode, it.v.mode, act.pos, it.v.pos);
        end
      end
    end
  end

  initial begin
    st_rst = 1'b1;
    idle(2);
    st_rst = 1'b0;
    idle(2);
    for (int k = 0; k < 4; k++) press(0);
    // CLOCK: 1 Hz tick and a held seconds-wrap level.
    idle(3);
    pulse_tick(1'b1);
    st_hit[0] = 1'b1; idle(5); st_hit[0] = 1'b0; idle(2);
    // SETUP: move to HOUR, increment, ticks and carries suppressed.
    press(0);
    press(1); press(1); press(2);
    pulse_tick(1'b1);
    st_hit[0] = 1'b1; idle(3);
    press(0);
    st_hit[0] = 1'b0; idle(2);
    // ALARM: increment, arm/disarm, then sw0 and sw2 together.
    press(2); press(3); press(3);
    st_btn = 4'b0101; step(); step(); st_btn = 4'b0000; step();
    // STOPWATCH: run, forward ticks and carries, stop.
    press(3);
    pulse_tick(1'b0); idle(2); pulse_tick(1'b0);
    st_hit[2] = 1'b1; idle(3); st_hit[2] = 1'b0;
    st_hit[3] = 1'b1; idle(2); st_hit[3] = 1'b0;
    press(3);
    pulse_tick(1'b0); idle(2);
    // Reach ALARM/MIN, then reset mid-operation.
    press(0); press(0); press(0); press(1);
    st_rst = 1'b1; step(); st_rst = 1'b0; idle(3);
    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      st_rst = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) st_btn[b] = ~st_btn[b];
        if ($urandom_range(0, 5) == 0) st_hit[b] = ~st_hit[b];
      end
      st_t1 = ($urandom_range(0, 4) == 0);
      st_t100 = ($urandom_range(0, 2) == 0);
      step();
    end
    st_rst = 1'b0; st_btn = 4'b0000; st_hit = 4'b0000; st_t1 = 1'b0; st_t100 = 1'b0;
    idle(2);
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
